sct_seq_driver: RTL and testbench

//  Sequential driver/capture stage wrapped around the combinational sct core.

---
 rtl/sct_pkg.sv | 19 +
 rtl/sct_skid_buf.sv | 57 +++++
 rtl/sct_seq_driver.sv | 116 +++++++++++
 tb/tb_sct_seq_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sct_pkg.sv
// Shared types for the sct sequential driver: FSM state, default widths, entry layout.
package sct_pkg;

    localparam int SCT_CNT_W = 8;
    localparam int SCT_RES_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } sct_seq_state_t;

    typedef struct packed {
        logic [SCT_CNT_W-1:0] tag;
        logic [SCT_RES_W-1:0] result;
    } sct_entry_t;

endpackage

// File: rtl/sct_skid_buf.sv
// Two-entry valid/ready buffer with registered outputs; free_o also counts a same-cycle pop,
// so a full buffer being drained still accepts a push.
module sct_skid_buf #(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         free_o,
    output logic         empty_next_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         pop;
    logic         do_push;

    assign out_valid_o  = (count_q != 2'd0);
    assign pop          = out_valid_o & out_ready_i;
    assign free_o       = (count_q != 2'd2) | out_ready_i;
    assign do_push      = push_i & free_o;
    assign count_d      = count_q + {1'b0, do_push} - {1'b0, pop};
    assign empty_next_o = (count_d == 2'd0);
    assign out_data_o   = mem_q[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == 1'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ do_push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sct_seq_driver.sv
// Counter/capture stage around the sct core: steps cnt_o, tags each core result and streams it out.
// Optional SCT_SEQ_PARITY_EN prepends an even-parity bit over {tag, result} to out_data.
module sct_seq_driver
    import sct_pkg::*;
#(
    parameter int                     CNT_W    = SCT_CNT_W,
    parameter int                     RES_W    = SCT_RES_W,
    parameter logic [SCT_CNT_W-1:0]   TERM_CNT = 8'hFF,
    parameter int                     STEP     = 1,
`ifdef SCT_SEQ_PARITY_EN
    localparam int                    DATA_W   = CNT_W + RES_W + 1
`else
    localparam int                    DATA_W   = CNT_W + RES_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  load_val,
    input  logic              abort,
    output logic [CNT_W-1:0]  cnt_o,
    input  logic [RES_W-1:0]  core_res,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    sct_seq_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q;
    logic              push;
    logic              buf_free;
    logic              buf_empty_next;
    logic [DATA_W-1:0] push_data;

`ifdef SCT_SEQ_PARITY_EN
    assign push_data = {^{cnt_q, core_res}, cnt_q, core_res};
`else
    assign push_data = {cnt_q, core_res};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = load_val;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (buf_free) begin
                    push = 1'b1;
                    if (cnt_q == CNT_W'(TERM_CNT)) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(STEP);
                    end
                end else begin
                    state_d = STALL;
                end
            end
            STALL: begin
                // Count is held here, so the resumed RUN pushes exactly the stalled sample.
                if (abort) begin
                    state_d = DRAIN;
                end else if (buf_free) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (buf_empty_next) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == DRAIN) && (state_d == IDLE);
        end
    end

    sct_skid_buf #(
        .W(DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .free_o      (buf_free),
        .empty_next_o(buf_empty_next),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    assign cnt_o = cnt_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_sct_seq_driver.sv
// Directed bench for sct_seq_driver (TERM_CNT=8'h13); honours SCT_SEQ_PARITY_EN when defined.
module tb_sct_seq_driver;
    import sct_pkg::*;

`ifdef SCT_SEQ_PARITY_EN
    localparam int DATA_W = 24;
`else
    localparam int DATA_W = 23;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        load_val;
    logic              abort;
    logic [7:0]        cnt_o;
    logic [14:0]       core_res;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              zero_res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    logic [DATA_W-1:0] beats[$];
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] core_fn(input logic [7:0] c);
        return {c[6:0] ^ 7'h55, c};
    endfunction

    assign core_res = zero_res ? 15'h0000 : core_fn(cnt_o);

    sct_seq_driver #(
        .TERM_CNT(8'h13)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .abort    (abort),
        .cnt_o    (cnt_o),
        .core_res (core_res),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Capture handshakes and verify the output holds while stalled.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("hold_data", 64'(out_data), 64'(prev_data));
            chk("hold_valid", 64'(out_valid), 64'd1);
        end
        if (out_valid && out_ready && !rst) begin
            beats.push_back(out_data);
            last_hs_cyc = cyc;
            $display("beat %0d data %0h cyc %0d", beats.size(), out_data, cyc);
        end
        prev_stall = out_valid & ~out_ready & ~rst;
        prev_data  = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] v);
        tick();
        start    = 1'b1;
        load_val = v;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit chk_lat);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("busy_at_done", 64'(busy), 64'd0);
            if (chk_lat) chk("done_lat", 64'(cyc - last_hs_cyc), 64'd1);
            @(negedge clk);
            chk("done_pulse", 64'(done), 64'd0);
        end
        $display("run end done=%0d beats=%0d", seen, beats.size());
    endtask

    task automatic check_seq(input logic [7:0] first, input int n);
        logic [7:0]        tag;
        logic [DATA_W-1:0] b;
        sct_entry_t        e;
        logic [14:0]       exp_res;
        chk("beat_count", 64'(beats.size()), 64'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            tag     = first + 8'(i);
            b       = beats[i];
            e       = sct_entry_t'(b[22:0]);
            exp_res = zero_res ? 15'h0000 : core_fn(tag);
            chk("tag", 64'(e.tag), 64'(tag));
            chk("result", 64'(e.result), 64'(exp_res));
`ifdef SCT_SEQ_PARITY_EN
            chk("parity", 64'(b[23]), 64'(^{tag, exp_res}));
`endif
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_val = 8'h00; abort = 1'b0;
        out_ready = 1'b1; zero_res = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;

        // Basic run 10..13
        beats.delete();
        start_run(8'h10);
        wait_done(100, 1'b1);
        check_seq(8'h10, 4);

        // Backpressure for 5 cycles after first beat
        beats.delete();
        start_run(8'h10);
        for (int i = 0; i < 20 && beats.size() < 1; i++) begin
            @(negedge clk);
            #1;
        end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("stall_cnt", 64'(cnt_o), 64'h13);
                chk("stall_state", 64'(dut.state_q), 64'(STALL));
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_busy", 64'(busy), 64'd1);
            end
            tick();
        end
        chk("stall_no_hs", 64'(beats.size()), 64'd1);
        out_ready = 1'b1;
        wait_done(50, 1'b1);
        check_seq(8'h10, 4);

        // Wrap-around FE,FF,00..13
        beats.delete();
        start_run(8'hFE);
        wait_done(100, 1'b1);
        check_seq(8'hFE, 22);

        // Abort in cycle 3 of a 16-beat run
        beats.delete();
        start_run(8'h04);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(50, 1'b0);
        check_seq(8'h04, 2);

        // All-zero core result; first entry {01, 0000}
        beats.delete();
        zero_res = 1'b1;
        start_run(8'h01);
        wait_done(100, 1'b1);
        check_seq(8'h01, 19);
`ifdef SCT_SEQ_PARITY_EN
        if (beats.size() > 0) begin
            logic [DATA_W-1:0] b0;
            b0 = beats[0];
            chk("parity_01", 64'(b0[23]), 64'd1);
        end
`endif
        zero_res = 1'b0;

        // Reset while out_valid is high
        beats.delete();
        out_ready = 1'b0;
        start_run(8'h10);
        repeat (4) tick();
        @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_cnt", 64'(cnt_o), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
            chk("post_rst_done", 64'(done), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
            tick();
        end
        chk("post_rst_beats", 64'(beats.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
